rgb_hue_fader: RTL

RGB_HUE_FADER -- requirements
Module: rgb_hue_fader

---
 rtl/rgb_hue_fader_if.sv | 22 ++
 rtl/rgb_hue_fader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rgb_hue_fader_if.sv
// Control and LED-drive bundle for the RGB hue fader: mode/brightness in,
// three LED drives and the current hue segment out.
interface rgb_hue_fader_if #(
    parameter int PWM_BITS = 8
);
    logic [1:0]          mode;
    logic [PWM_BITS-1:0] brightness;
    logic                RGB_R;
    logic                RGB_G;
    logic                RGB_B;
    logic [2:0]          seg;

    modport master (
        output mode, brightness,
        input  RGB_R, RGB_G, RGB_B, seg
    );

    modport slave (
        input  mode, brightness,
        output RGB_R, RGB_G, RGB_B, seg
    );
endinterface

// File: rtl/rgb_hue_fader.sv
// Colour-wheel LED driver: walks six hue segments (stepped or cross-faded),
// scales each channel by a global brightness and drives glitch-free PWM.
module rgb_hue_fader #(
    parameter int CLK_HZ      = 12000000,
    parameter int PWM_BITS    = 8,
    parameter int TICK_CYCLES = 46875,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    rgb_hue_fader_if.slave bus
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW = 2 * PWM_BITS;
    localparam logic [PWM_BITS-1:0] M         = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO      = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] P_ONE     = PWM_BITS'(1'b1);
    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0]       TICK_ONE  = TW'(1'b1);
    localparam logic [2:0]          LED_OFF   = {3{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_STEP = 2'b00,
        MODE_FADE = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    if (CLK_HZ < 1 || PWM_BITS < 2 || PWM_BITS > 12 || TICK_CYCLES < 2) begin : g_bad_params
        $error("rgb_hue_fader: illegal parameter set");
    end

    logic [TW-1:0]       tick_q, tick_d;
    logic [PWM_BITS-1:0] phase_q, phase_d;
    logic [2:0]          seg_q, seg_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [2:0][PWM_BITS-1:0] duty_q, duty_d;
    logic [2:0]          led_q, led_d;

    mode_e               mode_s;
    logic                run_s;
    logic                tick_s;
    logic [PWM_BITS-1:0] nphase_s;
    logic [2:0][PWM_BITS-1:0] level_s;
    logic [2:0][PWM_BITS-1:0] duty_calc_s;
    logic [2:0][PW-1:0]  prod_s;
    logic [PWM_BITS:0]   bplus_s;
    logic [2:0]          on_s;

    // Hue timebase: tick counter, phase and segment advance only while running.
    always_comb begin
        mode_s = mode_e'(bus.mode);
        run_s  = (mode_s == MODE_STEP) || (mode_s == MODE_FADE);
        tick_s = run_s && (tick_q == TICK_LAST);
        if (!run_s) begin
            tick_d = tick_q;
        end else if (tick_q == TICK_LAST) begin
            tick_d = {TW{1'b0}};
        end else begin
            tick_d = tick_q + TICK_ONE;
        end
        phase_d = tick_s ? (phase_q + P_ONE) : phase_q;
        // An upset segment value is pulled back to red rather than left stuck.
        if (seg_q > 3'd5) begin
            seg_d = 3'd0;
        end else if (tick_s && (phase_q == M)) begin
            seg_d = (seg_q == 3'd5) ? 3'd0 : (seg_q + 3'd1);
        end else begin
            seg_d = seg_q;
        end
    end

    // Per-channel target level (index 0 = R, 1 = G, 2 = B) for the current mode.
    always_comb begin
        nphase_s = M - phase_q;
        level_s  = {3{ZERO}};
        case (mode_s)
            MODE_STEP: begin
                case (seg_q)
                    3'd0:    level_s = {ZERO, ZERO, M};
                    3'd1:    level_s = {ZERO, M,    M};
                    3'd2:    level_s = {ZERO, M,    ZERO};
                    3'd3:    level_s = {M,    M,    ZERO};
                    3'd4:    level_s = {M,    ZERO, ZERO};
                    3'd5:    level_s = {M,    ZERO, M};
                    default: level_s = {3{ZERO}};
                endcase
            end
            MODE_FADE, MODE_HOLD: begin
                case (seg_q)
                    3'd0:    level_s = {ZERO,     phase_q,  M};
                    3'd1:    level_s = {ZERO,     M,        nphase_s};
                    3'd2:    level_s = {phase_q,  M,        ZERO};
                    3'd3:    level_s = {M,        nphase_s, ZERO};
                    3'd4:    level_s = {M,        ZERO,     phase_q};
                    3'd5:    level_s = {nphase_s, ZERO,     M};
                    default: level_s = {3{ZERO}};
                endcase
            end
            MODE_OFF: level_s = {3{ZERO}};
            default:  level_s = {3{ZERO}};
        endcase
    end

    // Brightness scaling, PWM compare and period-aligned duty reload.
    always_comb begin
        bplus_s = {1'b0, bus.brightness} + {{PWM_BITS{1'b0}}, 1'b1};
        for (int i = 0; i < 3; i++) begin
            prod_s[i]      = PW'(level_s[i]) * PW'(bplus_s);
            duty_calc_s[i] = PWM_BITS'(prod_s[i] >> PWM_BITS);
            on_s[i]        = (pwm_q < duty_q[i]);
        end
        pwm_d  = pwm_q + P_ONE;
        duty_d = (pwm_q == M) ? duty_calc_s : duty_q;
        led_d  = ACTIVE_LOW ? ~on_s : on_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= {TW{1'b0}};
            phase_q <= ZERO;
            seg_q   <= 3'd0;
            pwm_q   <= ZERO;
            duty_q  <= {3{ZERO}};
            led_q   <= LED_OFF;
        end else begin
            tick_q  <= tick_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
            led_q   <= led_d;
        end
    end

    assign bus.RGB_R = led_q[0];
    assign bus.RGB_G = led_q[1];
    assign bus.RGB_B = led_q[2];
    assign bus.seg   = seg_q;
endmodule
